decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered, handshaked RV32I decode stage, the pipelined successor to the combinational decoder. It sits between fetch and issue. It accepts one instruction word plus PC per cycle and fully decodes every RV32I base opcode into op code, register fields, valid flags and a sign-extended immediate. Results are held in a two-entry skid buffer so that backpressure from issue never drops or duplicates an instruction.

Parameters:
XLEN, 32, immediate/operand width; must be >= 32; immediates are sign-extended to XLEN.
PC_W, 32, width of the PC sideband carried alongside each instruction.
OP_W, 6, width of the op encoding; must hold every op constant plus `ILLEGAL.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all buffered entries (branch redirect)
in_valid  in  1  fetch offers an instruction
in_ready  out  1  stage accepts this cycle
in_instr  in  32  instruction word
in_pc  in  PC_W  PC of in_instr
out_valid  out  1  decoded entry available
out_ready  in  1  issue consumes this cycle
out_pc  out  PC_W  PC of decoded entry
out_op  out  OP_W  op constant (`ADD .. `EBREAK, `ILLEGAL)
out_rs1_v / out_rs2_v  out  1  source register read required
out_rs1 / out_rs2  out  5  source indices; 0 when the matching _v is 0
out_rd_v  out  1  writes rd; 0 when rd == x0
out_rd  out  5  destination index
out_imm_v  out  1  immediate used
out_imm  out  XLEN  sign-extended immediate; 0 when imm_v is 0
out_load_store  out  1  LB/LH/LW/LBU/LHU/SB/SH/SW
out_illegal  out  1  undefined encoding

Behaviour:
- Reset (rst=1 at edge): state EMPTY, out_valid=0, all out_* payload=0. in_ready=0 while rst is high.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- in_ready = !rst & (state != FULL). It is decoded from registered state only, with no combinational path from out_ready.
- Latency: an instruction accepted at edge N is visible on out_* after edge N, i.e. 1 cycle.
- States: EMPTY (0 entries), ONE (main register valid), FULL (main + skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & !consume -> FULL (new entry into skid); accept & consume -> ONE (new entry into main); consume only -> EMPTY.
  - FULL: consume -> ONE (skid moves to main); no accept is possible.
- Order is strictly FIFO; the skid entry is never output before the main entry.
- flush=1 at edge: state -> EMPTY and out_valid=0 next cycle. A simultaneous accept is discarded and a simultaneous consume is still counted by issue. flush has priority over everything except rst.
- rst mid-operation: identical to flush, plus payload cleared.
- Decode (combinational, registered on accept):
  - Immediates are built in I/S/B/U/J format and sign-extended from instr[31].
  - Shift-immediates: imm = zero-extended shamt instr[24:20].
  - Illegal when SLLI/SRLI have instr[31:25] != 0, or SRAI has instr[31:25] != 7'b0100000.
  - R-type: funct7 must be 0000000, or 0100000 only for SUB/SRA; anything else is illegal.
  - LUI/AUIPC/JAL: rs1_v=rs2_v=0. JALR requires funct3=000.
  - Branches, stores: rd_v=0. Loads/stores: out_load_store=1.
  - FENCE (opcode 0001111, funct3 000): op `FENCE, no register or immediate flags.
  - ECALL/EBREAK: exact encodings only (rs1=rd=0, funct3=0); otherwise illegal.
  - Illegal: op=`ILLEGAL, out_illegal=1, all _v=0, imm=0, load_store=0. The entry is still passed downstream in order.

Decomposition:
- Shared constants header (constants.v): all OP_W op encodings including `ILLEGAL and `FENCE, plus opcode/funct3 literals.
- One sub-module, rv32i_decode_comb: purely combinational instr -> decoded fields. It is the successor of the old decoder and is instantiated once at the input. decode_stage adds buffering, handshake and flush.

Test Plan:
- Reset, then in_instr=0xFFF00093 (ADDI x1,x0,-1) with out_ready=1 -> next cycle out_op=`ADDI, rs1_v=1, rs1=0, rd_v=1, rd=1, imm_v=1, out_imm=0xFFFFFFFF, out_pc echoed.
- 0x00812283 (LW x5,8(x2)) -> out_load_store=1, rs1=2, rd=5, out_imm=8; 0xFE000EE3 (BEQ x0,x0,-4) -> rd_v=0, out_imm=0xFFFFFFFC.
- Offer 3 consecutive instructions with out_ready=0 -> first two accepted, in_ready=0 from cycle 2, third held by fetch. Then out_ready=1 -> all three emerge in order, none duplicated.
- in_instr=0x00000000 and 0x40001013 (bad SLLI funct7) -> out_illegal=1, out_op=`ILLEGAL, all _v=0, out_imm=0.
- State FULL, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1. The flushed-cycle input never appears at the output.
- rst asserted while state is ONE -> out_valid=0 and in_ready=0 during rst. After release, the first accepted ADDI decodes normally with 1-cycle latency.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I decode stage: op encodings, opcode
// literals, the decoded-field bundle and the skid-buffer state.
package decode_stage_pkg;

    // Op encodings. Every base RV32I instruction has its own value;
    // ILLEGAL sits at the top of the 6-bit space.
    typedef enum logic [5:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_FENCE, OP_ECALL, OP_EBREAK,
        OP_ILLEGAL = 6'h3f
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Decoded fields; imm is the 32-bit form, widened to XLEN at output.
    typedef struct packed {
        op_e         op;
        logic        rs1_v;
        logic        rs2_v;
        logic        rd_v;
        logic        imm_v;
        logic        ls;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_e;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and issue-side handshake bundle of the decode stage.
// master: fetch/issue environment; slave: the decode stage itself.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32,
    parameter int OP_W = 6
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [OP_W-1:0] out_op;
    logic            out_rs1_v;
    logic            out_rs2_v;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic            out_rd_v;
    logic [4:0]      out_rd;
    logic            out_imm_v;
    logic [XLEN-1:0] out_imm;
    logic            out_load_store;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_op,
        input  out_rs1_v, out_rs2_v, out_rs1, out_rs2,
        input  out_rd_v, out_rd, out_imm_v, out_imm,
        input  out_load_store, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_op,
        output out_rs1_v, out_rs2_v, out_rs1, out_rs2,
        output out_rd_v, out_rd, out_imm_v, out_imm,
        output out_load_store, out_illegal
    );
endinterface

// File: rtl/rv32i_decode_comb.sv
// Combinational RV32I decoder: instruction word -> decoded fields.
// Ports: instr (32-bit word in), dec (dec_t bundle out).
module rv32i_decode_comb
    import decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    op_e         op;

    assign opc = instr[6:0];
    assign rd  = instr[11:7];
    assign f3  = instr[14:12];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign f7  = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    // Op selection; anything not matched stays ILLEGAL.
    always_comb begin
        op = OP_ILLEGAL;
        case (opc)
            OPC_LUI:   op = OP_LUI;
            OPC_AUIPC: op = OP_AUIPC;
            OPC_JAL:   op = OP_JAL;
            OPC_JALR:  if (f3 == 3'b000) op = OP_JALR;
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                case (f3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                case (f3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_OPIMM: begin
                case (f3)
                    3'b000: op = OP_ADDI;
                    3'b010: op = OP_SLTI;
                    3'b011: op = OP_SLTIU;
                    3'b100: op = OP_XORI;
                    3'b110: op = OP_ORI;
                    3'b111: op = OP_ANDI;
                    3'b001: if (f7 == F7_ZERO) op = OP_SLLI;
                    default: begin
                        if (f7 == F7_ZERO)
                            op = OP_SRLI;
                        else if (f7 == F7_ALT)
                            op = OP_SRAI;
                    end
                endcase
            end
            OPC_OP: begin
                if (f7 == F7_ZERO) begin
                    case (f3)
                        3'b000:  op = OP_ADD;
                        3'b001:  op = OP_SLL;
                        3'b010:  op = OP_SLT;
                        3'b011:  op = OP_SLTU;
                        3'b100:  op = OP_XOR;
                        3'b101:  op = OP_SRL;
                        3'b110:  op = OP_OR;
                        default: op = OP_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        3'b000:  op = OP_SUB;
                        3'b101:  op = OP_SRA;
                        default: op = OP_ILLEGAL;
                    endcase
                end
            end
            OPC_MISC: if (f3 == 3'b000) op = OP_FENCE;
            OPC_SYSTEM: begin
                if (rs1 == 5'd0 && rd == 5'd0 && f3 == 3'b000) begin
                    if (instr[31:20] == 12'h000)
                        op = OP_ECALL;
                    else if (instr[31:20] == 12'h001)
                        op = OP_EBREAK;
                end
            end
            default: op = OP_ILLEGAL;
        endcase
    end

    // Operand flags by format; an illegal word keeps everything zero.
    always_comb begin
        dec    = '0;
        dec.op = op;
        if (op == OP_ILLEGAL) begin
            dec.ill = 1'b1;
        end else begin
            case (opc)
                OPC_LUI, OPC_AUIPC: begin
                    dec.rd_v  = 1'b1;
                    dec.imm_v = 1'b1;
                    dec.imm   = imm_u;
                end
                OPC_JAL: begin
                    dec.rd_v  = 1'b1;
                    dec.imm_v = 1'b1;
                    dec.imm   = imm_j;
                end
                OPC_JALR: begin
                    dec.rs1_v = 1'b1;
                    dec.rd_v  = 1'b1;
                    dec.imm_v = 1'b1;
                    dec.imm   = imm_i;
                end
                OPC_BRANCH: begin
                    dec.rs1_v = 1'b1;
                    dec.rs2_v = 1'b1;
                    dec.imm_v = 1'b1;
                    dec.imm   = imm_b;
                end
                OPC_LOAD: begin
                    dec.rs1_v = 1'b1;
                    dec.rd_v  = 1'b1;
                    dec.imm_v = 1'b1;
                    dec.ls    = 1'b1;
                    dec.imm   = imm_i;
                end
                OPC_STORE: begin
                    dec.rs1_v = 1'b1;
                    dec.rs2_v = 1'b1;
                    dec.imm_v = 1'b1;
                    dec.ls    = 1'b1;
                    dec.imm   = imm_s;
                end
                OPC_OPIMM: begin
                    dec.rs1_v = 1'b1;
                    dec.rd_v  = 1'b1;
                    dec.imm_v = 1'b1;
                    // Shifts carry a zero-extended shamt, not imm_i.
                    if (f3 == 3'b001 || f3 == 3'b101)
                        dec.imm = {27'd0, rs2};
                    else
                        dec.imm = imm_i;
                end
                OPC_OP: begin
                    dec.rs1_v = 1'b1;
                    dec.rs2_v = 1'b1;
                    dec.rd_v  = 1'b1;
                end
                default: ;
            endcase
            // Writes to x0 are architecturally dropped.
            if (rd == 5'd0)
                dec.rd_v = 1'b0;
            dec.rs1 = dec.rs1_v ? rs1 : 5'd0;
            dec.rs2 = dec.rs2_v ? rs2 : 5'd0;
            dec.rd  = dec.rd_v ? rd : 5'd0;
        end
    end
endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a two-entry skid buffer.
// Ports: clk, rst (sync, active high), flush, bus (slave handshake).
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32,
    parameter int OP_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    decode_stage_if.slave  bus
);
    state_e          state_q;
    state_e          state_d;
    dec_t            in_dec;
    dec_t            main_q;
    dec_t            skid_q;
    logic [PC_W-1:0] main_pc_q;
    logic [PC_W-1:0] skid_pc_q;
    logic            acc;
    logic            con;
    logic            load_main;
    logic            load_skid;
    logic            promote;

    rv32i_decode_comb u_dec (
        .instr (bus.in_instr),
        .dec   (in_dec)
    );

    // Ready comes from registered state only, never from out_ready.
    assign bus.in_ready  = !rst && (state_q != ST_FULL);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign acc = bus.in_valid && bus.in_ready;
    assign con = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        promote   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (acc && !con) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (acc && con) begin
                    load_main = 1'b1;
                end else if (con) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (con) begin
                    state_d = ST_ONE;
                    promote = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A redirect drops everything, including a same-cycle accept.
        if (flush) begin
            state_d   = ST_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            promote   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            main_pc_q <= '0;
            skid_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q    <= in_dec;
                main_pc_q <= bus.in_pc;
            end else if (promote) begin
                main_q    <= skid_q;
                main_pc_q <= skid_pc_q;
            end
            if (load_skid) begin
                skid_q    <= in_dec;
                skid_pc_q <= bus.in_pc;
            end
        end
    end

    assign bus.out_pc         = main_pc_q;
    assign bus.out_op         = OP_W'(main_q.op);
    assign bus.out_rs1_v      = main_q.rs1_v;
    assign bus.out_rs2_v      = main_q.rs2_v;
    assign bus.out_rs1        = main_q.rs1;
    assign bus.out_rs2        = main_q.rs2;
    assign bus.out_rd_v       = main_q.rd_v;
    assign bus.out_rd         = main_q.rd;
    assign bus.out_imm_v      = main_q.imm_v;
    assign bus.out_imm        = XLEN'($signed(main_q.imm));
    assign bus.out_load_store = main_q.ls;
    assign bus.out_illegal    = main_q.ill;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a
// randomized run against a mask/match reference decoder and FIFO model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int F_R  = 0;
    localparam int F_I  = 1;
    localparam int F_L  = 2;
    localparam int F_S  = 3;
    localparam int F_B  = 4;
    localparam int F_U  = 5;
    localparam int F_J  = 6;
    localparam int F_SH = 7;
    localparam int F_N  = 8;

    typedef struct packed {
        logic [5:0]  op;
        logic        rs1_v;
        logic        rs2_v;
        logic        rd_v;
        logic        imm_v;
        logic        ls;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] pat_mask[$];
    logic [31:0] pat_match[$];
    op_e         pat_op[$];
    int          pat_fmt[$];

    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(logic [31:0] m, logic [31:0] v, op_e o, int f);
        pat_mask.push_back(m);
        pat_match.push_back(v);
        pat_op.push_back(o);
        pat_fmt.push_back(f);
    endtask

    task automatic init_table();
        add(32'h7f, 32'h37, OP_LUI, F_U);
        add(32'h7f, 32'h17, OP_AUIPC, F_U);
        add(32'h7f, 32'h6f, OP_JAL, F_J);
        add(32'h707f, 32'h67, OP_JALR, F_I);
        add(32'h707f, 32'h0063, OP_BEQ, F_B);
        add(32'h707f, 32'h1063, OP_BNE, F_B);
        add(32'h707f, 32'h4063, OP_BLT, F_B);
        add(32'h707f, 32'h5063, OP_BGE, F_B);
        add(32'h707f, 32'h6063, OP_BLTU, F_B);
        add(32'h707f, 32'h7063, OP_BGEU, F_B);
        add(32'h707f, 32'h0003, OP_LB, F_L);
        add(32'h707f, 32'h1003, OP_LH, F_L);
        add(32'h707f, 32'h2003, OP_LW, F_L);
        add(32'h707f, 32'h4003, OP_LBU, F_L);
        add(32'h707f, 32'h5003, OP_LHU, F_L);
        add(32'h707f, 32'h0023, OP_SB, F_S);
        add(32'h707f, 32'h1023, OP_SH, F_S);
        add(32'h707f, 32'h2023, OP_SW, F_S);
        add(32'h707f, 32'h0013, OP_ADDI, F_I);
        add(32'h707f, 32'h2013, OP_SLTI, F_I);
        add(32'h707f, 32'h3013, OP_SLTIU, F_I);
        add(32'h707f, 32'h4013, OP_XORI, F_I);
        add(32'h707f, 32'h6013, OP_ORI, F_I);
        add(32'h707f, 32'h7013, OP_ANDI, F_I);
        add(32'hfe00707f, 32'h1013, OP_SLLI, F_SH);
        add(32'hfe00707f, 32'h5013, OP_SRLI, F_SH);
        add(32'hfe00707f, 32'h40005013, OP_SRAI, F_SH);
        add(32'hfe00707f, 32'h0033, OP_ADD, F_R);
        add(32'hfe00707f, 32'h40000033, OP_SUB, F_R);
        add(32'hfe00707f, 32'h1033, OP_SLL, F_R);
        add(32'hfe00707f, 32'h2033, OP_SLT, F_R);
        add(32'hfe00707f, 32'h3033, OP_SLTU, F_R);
        add(32'hfe00707f, 32'h4033, OP_XOR, F_R);
        add(32'hfe00707f, 32'h5033, OP_SRL, F_R);
        add(32'hfe00707f, 32'h40005033, OP_SRA, F_R);
        add(32'hfe00707f, 32'h6033, OP_OR, F_R);
        add(32'hfe00707f, 32'h7033, OP_AND, F_R);
        add(32'h707f, 32'h000f, OP_FENCE, F_N);
        add(32'hffffffff, 32'h00000073, OP_ECALL, F_N);
        add(32'hffffffff, 32'h00100073, OP_EBREAK, F_N);
    endtask

    // Reference decoder: first mask/match hit wins, else illegal.
    function automatic exp_t ref_decode(logic [31:0] w, logic [31:0] pc);
        exp_t e;
        int   v;
        int   f;
        e     = '0;
        e.op  = OP_ILLEGAL;
        e.ill = 1'b1;
        e.pc  = pc;
        for (int i = 0; i < pat_mask.size(); i++) begin
            if ((w & pat_mask[i]) == pat_match[i]) begin
                f       = pat_fmt[i];
                e.op    = pat_op[i];
                e.ill   = 1'b0;
                e.rs1_v = f inside {F_R, F_I, F_L, F_S, F_B, F_SH};
                e.rs2_v = f inside {F_R, F_S, F_B};
                e.rd_v  = (f inside {F_R, F_I, F_L, F_SH, F_U, F_J})
                          && (w[11:7] != 5'd0);
                e.imm_v = !(f inside {F_R, F_N});
                e.ls    = f inside {F_L, F_S};
                case (f)
                    F_I, F_L: v = int'(w[31:20])
                                  - (w[31] ? 4096 : 0);
                    F_S: v = int'({w[31:25], w[11:7]})
                             - (w[31] ? 4096 : 0);
                    F_B: v = 2 * int'({w[31], w[7], w[30:25], w[11:8]})
                             - (w[31] ? 8192 : 0);
                    F_U: v = int'(w[31:12]) << 12;
                    F_J: v = 2 * int'({w[31], w[19:12], w[20], w[30:21]})
                             - (w[31] ? (1 << 21) : 0);
                    F_SH: v = int'(w[24:20]);
                    default: v = 0;
                endcase
                e.imm = 32'(v);
                e.rs1 = e.rs1_v ? w[19:15] : 5'd0;
                e.rs2 = e.rs2_v ? w[24:20] : 5'd0;
                e.rd  = e.rd_v ? w[11:7] : 5'd0;
                break;
            end
        end
        return e;
    endfunction

    function automatic exp_t mk(logic [5:0] op, logic [5:0] fl,
                                logic [4:0] r1, logic [4:0] r2,
                                logic [4:0] rd, logic [31:0] imm,
                                logic [31:0] pc);
        exp_t e;
        e.op = op;
        {e.rs1_v, e.rs2_v, e.rd_v, e.imm_v, e.ls, e.ill} = fl;
        e.rs1 = r1;
        e.rs2 = r2;
        e.rd  = rd;
        e.imm = imm;
        e.pc  = pc;
        return e;
    endfunction

    // rd is only meaningful when rd_v is set.
    function automatic exp_t sample();
        exp_t a;
        a.op    = bus.out_op;
        a.rs1_v = bus.out_rs1_v;
        a.rs2_v = bus.out_rs2_v;
        a.rd_v  = bus.out_rd_v;
        a.imm_v = bus.out_imm_v;
        a.ls    = bus.out_load_store;
        a.ill   = bus.out_illegal;
        a.rs1   = bus.out_rs1;
        a.rs2   = bus.out_rs2;
        a.rd    = bus.out_rd_v ? bus.out_rd : 5'd0;
        a.imm   = bus.out_imm;
        a.pc    = bus.out_pc;
        return a;
    endfunction

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        flush         = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        exp_t a;
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", bus.in_ready);
        end
        a = sample();
        checks++;
        if (a !== exp_t'(0)) begin
            errors++;
            $display("FAIL reset_payload: got %h want 0", a);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_addi();
        exp_t a;
        exp_t e;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hfff00093;
        bus.in_pc     = 32'h100;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        a = sample();
        e = mk(OP_ADDI, 6'b101100, 5'd0, 5'd0, 5'd1, 32'hffffffff, 32'h100);
        checks++;
        if (bus.out_valid !== 1'b1 || a !== e) begin
            errors++;
            $display("FAIL addi: got v=%b %h want %h", bus.out_valid, a, e);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_drain: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_load_branch();
        exp_t a;
        exp_t e;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00812283;
        bus.in_pc     = 32'h104;
        bus.out_ready = 1'b1;
        tick();
        a = sample();
        e = mk(OP_LW, 6'b101110, 5'd2, 5'd0, 5'd5, 32'h8, 32'h104);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL lw: got %h want %h", a, e);
        end
        bus.in_instr = 32'hfe000ee3;
        bus.in_pc    = 32'h108;
        tick();
        bus.in_valid = 1'b0;
        a = sample();
        e = mk(OP_BEQ, 6'b110100, 5'd0, 5'd0, 5'd0, 32'hfffffffc, 32'h108);
        checks++;
        if (bus.out_valid !== 1'b1 || a !== e) begin
            errors++;
            $display("FAIL beq: got v=%b %h want %h", bus.out_valid, a, e);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [31:0] words[2];
        exp_t a;
        exp_t e;
        words[0] = 32'h00000000;
        words[1] = 32'h40001013;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_instr  = words[i];
            bus.in_pc     = 32'h200 + 32'(i);
            bus.out_ready = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            a = sample();
            e = mk(OP_ILLEGAL, 6'b000001, 5'd0, 5'd0, 5'd0, 32'd0,
                   32'h200 + 32'(i));
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL illegal_%0d: got %h want %h", i, a, e);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        logic [31:0] want[3];
        want[0] = 32'h300;
        want[1] = 32'h304;
        want[2] = 32'h308;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_instr = 32'h00100093 + (32'(i) << 20);
            bus.in_pc    = want[i];
            checks++;
            if (bus.in_ready !== (i < 2)) begin
                errors++;
                $display("FAIL bp_ready_%0d: got %b want %b",
                         i, bus.in_ready, (i < 2));
            end
            if (i < 2)
                tick();
        end
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_pc !== want[0]) begin
            errors++;
            $display("FAIL bp_hold: got rdy=%b pc=%h want 0 %h",
                     bus.in_ready, bus.out_pc, want[0]);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid)
                got.push_back(bus.out_pc);
            if (bus.in_valid && bus.in_ready) begin
                tick();
                bus.in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d want 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL bp_order_%0d: got %h want %h",
                         i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_flush();
        bit seen;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00000013;
        bus.in_pc     = 32'h400;
        tick();
        bus.in_pc = 32'h404;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: got rdy=%b want 0", bus.in_ready);
        end
        flush     = 1'b1;
        bus.in_pc = 32'hdead0000;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full_after: got v=%b rdy=%b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h500;
        tick();
        flush     = 1'b1;
        bus.in_pc = 32'h504;
        tick();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (bus.out_valid)
                seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_accept: got valid=1 want 0");
        end
    endtask

    task automatic test_rst_mid();
        exp_t a;
        exp_t e;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00000013;
        bus.in_pc     = 32'h600;
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: got %b want 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: got v=%b pc=%h want 0 0",
                     bus.out_valid, bus.out_pc);
        end
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hfff00093;
        bus.in_pc     = 32'h700;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        a = sample();
        e = mk(OP_ADDI, 6'b101100, 5'd0, 5'd0, 5'd1, 32'hffffffff, 32'h700);
        checks++;
        if (bus.out_valid !== 1'b1 || a !== e) begin
            errors++;
            $display("FAIL rst_then_addi: got v=%b %h want %h",
                     bus.out_valid, a, e);
        end
        tick();
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        a;
        exp_t        e;
        bit          acc;
        bit          con;
        logic [31:0] w;
        int          k;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                w = $urandom;
            end else begin
                k = $urandom_range(0, pat_mask.size() - 1);
                w = ($urandom & ~pat_mask[k]) | pat_match[k];
            end
            bus.in_instr = w;
            bus.in_pc    = $urandom;
            #1;
            checks++;
            if (bus.out_valid !== (q.size() > 0) ||
                bus.in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rnd_hs_%0d: got v=%b r=%b want occ=%0d",
                         n, bus.out_valid, bus.in_ready, q.size());
            end
            if (q.size() > 0) begin
                a = sample();
                checks++;
                if (a !== q[0]) begin
                    errors++;
                    $display("FAIL rnd_out_%0d: got %h want %h",
                             n, a, q[0]);
                end
            end
            acc = bus.in_valid && (q.size() < 2);
            con = bus.out_ready && (q.size() > 0);
            e   = ref_decode(w, bus.in_pc);
            tick();
            if (con)
                void'(q.pop_front());
            if (acc)
                q.push_back(e);
            if (flush)
                q.delete();
        end
        flush        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_pc     = 32'd0;
        bus.out_ready = 1'b0;
        init_table();
        test_reset();
        test_addi();
        test_load_branch();
        test_illegal();
        drain();
        test_back_to_back();
        drain();
        test_flush();
        drain();
        test_rst_mid();
        drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
